sr_pattern_driver: RTL
======================

Name: sr_pattern_driver

Overview:
- Stimulus/checker that drives the S/R inputs of an SR flip-flop so that its output q follows a programmed bit pattern.
- Reads q back after each step and counts mismatches.
- Sits on the input side of an SR flip-flop, in a self-checking wrapper or a test harness.
- One pattern bit is handled per two clocks: a DRIVE cycle, then a CHECK cycle.

Parameters:
- PAT_W, 8: pattern length in bits. Must be at least 2.
- CNT_W, 4: error counter width. The counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- pattern  in  PAT_W  target q sequence; LSB is applied first; latched on start.
- q_fb  in  1  q output of the driven SR flip-flop.
- s  out  1  set excitation to the flip-flop.
- r  out  1  reset excitation to the flip-flop.
- busy  out  1  high in DRIVE and CHECK.
- done  out  1  one-cycle pulse in the DONE state.
- err_cnt  out  CNT_W  mismatch count for the current/last run.
- pass  out  1  registered; high when the last run had err_cnt==0; held until the next start.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; shift register and bit index are cleared.
  - s=0, r=0, busy=0, done=0, err_cnt=0, pass=0.
  - rst has priority over every other input in every state; a run interrupted by reset never produces done.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - s=r=0.
  - start=1 at an edge: latch pattern into pat_sr, set idx=0, clear err_cnt and pass, go to DRIVE.
  - busy rises in the cycle after start is sampled.
- DRIVE:
  - Target t = pat_sr[0].
  - s/r are a combinational decode of state, t and q_fb:
    - t=1, q_fb=0: s=1, r=0.
    - t=0, q_fb=1: s=0, r=1.
    - t==q_fb: s=0, r=0 (hold).
  - Always go to CHECK next.
  - The flip-flop captures s/r on the edge that ends DRIVE.
- CHECK:
  - s=r=0.
  - At the closing edge: if q_fb!=t, increment err_cnt, saturating at 2^CNT_W-1.
  - Shift pat_sr right by 1 and increment idx.
  - If idx==PAT_W-1, go to DONE; otherwise go to DRIVE.
- DONE (exactly one cycle):
  - done=1, busy=0, s=r=0.
  - At the closing edge: pass <= (err_cnt==0), then go to IDLE.
- Latency: start is sampled at edge E0. DRIVE cycles are cycles 1,3,…,2*PAT_W-1. done is high during cycle 2*PAT_W+1 after E0. pass is valid from cycle 2*PAT_W+2.
- start while busy or in DONE is ignored, with no queuing. start held high continuously relaunches on the first IDLE cycle.
- pattern changes after launch have no effect on the run.
- s and r are never both 1 in any state, including with the optional feature enabled.
- err_cnt holds its final value in IDLE until the next start.

Optional Feature:
- Macro: SR_REDUNDANT_DRIVE_EN.
- Defined: in DRIVE with t==q_fb, the block drives the redundant excitation instead of hold: t=1 gives s=1,r=0; t=0 gives s=0,r=1. Every DRIVE cycle therefore asserts exactly one of s/r.
- Undefined: the hold encoding s=r=0 is used when t==q_fb.
- All other behaviour and timing are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles mid-idle -> s=r=busy=done=pass=0, err_cnt=0 on the cycle after.
- Correct flip-flop model on s/r/q_fb, q initially 0, pattern=8'b1010_0110, start pulsed -> busy high for 16 cycles; done pulse at cycle 17; pass=1; err_cnt=0. s/r per DRIVE: bit0 (t=0, q=0) s=r=0; bit1 s=1; bit2 hold; bit3 r=1.
- q_fb tied 0, pattern=8'hFF, CNT_W=4 -> s=1 in all 8 DRIVE cycles; err_cnt=8; pass=0. With CNT_W=2 -> err_cnt=3 (saturated).
- start held high across a run -> exactly one done per run; second run starts on the first IDLE cycle after done. Changing pattern mid-run does not alter the s/r sequence.
- rst=1 in cycle 5 of a run (a DRIVE cycle) -> next cycle busy=0, s=r=0, err_cnt=0; no done pulse; a new start then runs normally.
- Assertion for the whole bench, both macro settings -> !(s && r). With SR_REDUNDANT_DRIVE_EN and pattern=8'h00, q=0 -> r=1 in all 8 DRIVE cycles; pass=1.

Source files
------------

// File: rtl/sr_pattern_driver.sv
// sr_pattern_driver
//   Drives the S/R excitation of an external SR flip-flop so that its output
//   follows a programmed bit pattern, LSB first. Each bit takes two clocks:
//     DRIVE - s/r decoded from the target bit and the current q_fb.
//     CHECK - s=r=0; q_fb is compared against the target bit.
//   Mismatches go into a saturating counter. pass is registered at the end
//   of the run.
//
//   Optional build macro SR_REDUNDANT_DRIVE_EN:
//     When the target bit already equals q_fb, DRIVE asserts the matching
//     excitation (s for 1, r for 0) instead of holding with s=r=0.
//
// Parameters
//   PAT_W   pattern length in bits (must be at least 2)
//   CNT_W   error counter width; the counter saturates at 2^CNT_W-1
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    launch request; sampled only in IDLE
//   pattern  target q sequence; latched on start
//   q_fb     q output of the driven flip-flop
//   s, r     set/reset excitation; never both high
//   busy     high in DRIVE and CHECK
//   done     one-cycle pulse at the end of a run
//   err_cnt  mismatch count of the current or last run
//   pass     last run had no mismatches; held until the next start
module sr_pattern_driver #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             pass
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [PAT_W-1:0] pat_sr;
  logic [IDX_W-1:0] idx;
  logic             t;

  // The current target bit is always the LSB of the shift register.
  assign t = pat_sr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pat_sr  <= '0;
      idx     <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_sr  <= pattern;
            idx     <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            state   <= DRIVE;
          end
        end
        DRIVE: state <= CHECK;
        CHECK: begin
          if ((q_fb != t) && (err_cnt != {CNT_W{1'b1}}))
            err_cnt <= err_cnt + CNT_W'(1);
          pat_sr <= pat_sr >> 1;
          idx    <= idx + IDX_W'(1);
          state  <= (idx == LAST_IDX) ? DONE : DRIVE;
        end
        DONE: begin
          pass  <= (err_cnt == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // s/r follow q_fb within the DRIVE cycle so the flip-flop sees the right
  // excitation on the edge that closes DRIVE. Both decodes are one-hot or
  // zero by construction, so s and r can never be high together.
  always_comb begin
    s = 1'b0;
    r = 1'b0;
    if (state == DRIVE) begin
`ifdef SR_REDUNDANT_DRIVE_EN
      s = t;
      r = ~t;
`else
      s = t & ~q_fb;
      r = ~t & q_fb;
`endif
    end
  end

  assign busy = (state == DRIVE) || (state == CHECK);
  assign done = (state == DONE);

endmodule
